bridge2xheep_cmdq: RTL

Parametrised successor to the MCU-to-X-HEEP loader bridge. MCU commands (load address, write word, read word) are buffered in a FIFO and executed as single OBI master transactions, with an auto-incrementing address counter. Read data returns to the MCU through a valid/ready response slot. It sits between the CW305 MCU register interface and an X-HEEP OBI slave port, and adds queued writes and memory read-back for verification of loaded sections.

---
 rtl/bridge2xheep_pkg.sv | 17 +
 rtl/bridge_cmd_fifo.sv | 65 ++++++
 rtl/bridge2xheep_cmdq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bridge2xheep_pkg.sv
// rtl/bridge2xheep_pkg.sv - op and state encodings for the MCU-to-X-HEEP command bridge
package bridge2xheep_pkg;

  typedef enum logic [1:0] {
    LOAD_ADDR = 2'd0,
    WRITE     = 2'd1,
    READ      = 2'd2,
    RSVD      = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/bridge_cmd_fifo.sv
// rtl/bridge_cmd_fifo.sv - synchronous command FIFO with full/empty/level
module bridge_cmd_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [PW:0]      level
);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/bridge2xheep_cmdq.sv
// rtl/bridge2xheep_cmdq.sv - queued MCU command engine driving single OBI master transactions
module bridge2xheep_cmdq
  import bridge2xheep_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_STEP  = 4,
  localparam int CMD_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH,
  localparam int LVL_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [CMD_WIDTH-1:0]    cmd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    busy,
  output logic [LVL_WIDTH-1:0]    fifo_level,
  output logic [ADDR_WIDTH-1:0]   cur_addr,
  output logic                    err_op,
  output logic                    req,
  output logic                    we,
  output logic [DATA_WIDTH/8-1:0] be,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    gnt,
  input  logic                    rvalid,
  input  logic [DATA_WIDTH-1:0]   rdata
);

  bridge_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    err_op_q, err_op_d;

  logic                    fifo_full, fifo_empty, fifo_pop;
  logic [CMD_WIDTH+1:0]    head;
  cmd_op_e                 head_op;
  logic [CMD_WIDTH-1:0]    head_data;

  assign head_op   = cmd_op_e'(head[CMD_WIDTH+1:CMD_WIDTH]);
  assign head_data = head[CMD_WIDTH-1:0];

  bridge_cmd_fifo #(
    .WIDTH(CMD_WIDTH + 2),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (cmd_valid && cmd_ready),
    .push_data({cmd_op, cmd_data}),
    .pop      (fifo_pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    err_op_d    = err_op_q;
    fifo_pop    = 1'b0;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          case (head_op)
            LOAD_ADDR: begin
              fifo_pop = 1'b1;
              addr_d   = head_data[ADDR_WIDTH-1:0];
            end
            WRITE: begin
              fifo_pop = 1'b1;
              we_d     = 1'b1;
              wdata_d  = head_data[DATA_WIDTH-1:0];
              state_d  = REQ;
            end
            READ: begin
              // An unconsumed response would be overwritten, so hold the read at the head.
              if (!rsp_valid_q) begin
                fifo_pop = 1'b1;
                we_d     = 1'b0;
                state_d  = REQ;
              end
            end
            default: begin
              fifo_pop = 1'b1;
              err_op_d = 1'b1;
            end
          endcase
        end
      end
      REQ: begin
        if (gnt) begin
          state_d = WAIT_R;
          addr_d  = addr_q + ADDR_WIDTH'(ADDR_STEP);
        end
      end
      WAIT_R: begin
        if (rvalid) begin
          state_d = IDLE;
          if (!we_q) begin
            rsp_data_d  = rdata;
            rsp_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_op_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_op_q    <= err_op_d;
    end
  end

  assign cmd_ready = !fifo_full;
  assign req       = (state_q == REQ);
  assign we        = we_q;
  assign be        = '1;
  assign addr      = addr_q;
  assign cur_addr  = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err_op    = err_op_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule
